rand_dispatch: RTL

//  Shares the single 128-bit LFSR random source among NUM_REQ verification-platform consumers
//  (key, plaintext and mask stimulus generators). Buffers fresh LFSR words and serves each word at most once.

---
 rtl/rand_dispatch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rand_dispatch.sv
// Shares one LFSR word stream among NUM_REQ consumers: discards warm-up output, buffers
// fresh words, serves each word once in round-robin order and flags a stuck LFSR.
module rand_dispatch #(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned WARMUP      = 16,
  parameter int unsigned STUCK_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   random128,
  input  logic [NUM_REQ-1:0] req,
  input  logic               clr_stuck,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rand_out,
  output logic [2:0]         buf_cnt,
  output logic               lfsr_stuck,
  output logic [31:0]        served_cnt
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WW = $clog2(WARMUP + 1);
  localparam int unsigned BW = $clog2(STUCK_LIMIT + 1);

  typedef enum logic [1:0] {S_WARM, S_RUN, S_STUCK} state_e;

  state_e             state_q, state_d;
  logic [WW-1:0]      warm_q, warm_d;
  logic [BW-1:0]      bad_q, bad_d;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   buf_q [DEPTH];
  logic [WIDTH-1:0]   buf_d [DEPTH];
  logic [2:0]         cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   rand_q, rand_d;
  logic               stuck_q, stuck_d;
  logic [31:0]        served_q, served_d;

  logic               good, push, pop, found;
  logic [NUM_REQ-1:0] elig;
  logic [PW-1:0]      sel, idx;
  logic [2:0]         wr_pos;

  // Round-robin search starting at ptr; a requester granted this cycle is masked.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    pop = found && (cnt_q != '0);
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    bad_d   = bad_q;
    stuck_d = stuck_q;
    good    = (random128 != prev_q) && (random128 != '0);
    case (state_q)
      S_WARM: begin
        if (warm_q == WW'(WARMUP - 1)) state_d = S_RUN;
        else                           warm_d  = warm_q + WW'(1);
      end
      S_RUN: begin
        if (good) begin
          bad_d = '0;
        end else begin
          bad_d = bad_q + BW'(1);
          if (bad_d == BW'(STUCK_LIMIT)) begin
            state_d = S_STUCK;
            stuck_d = 1'b1;
          end
        end
      end
      S_STUCK: begin
        if (clr_stuck) begin
          state_d = S_RUN;
          stuck_d = 1'b0;
          bad_d   = '0;
        end
      end
      default: state_d = S_WARM;
    endcase
  end

  // The pop shifts the buffer first, so a same-cycle push lands behind the remaining words.
  always_comb begin
    push   = (state_q == S_RUN) && good && ((cnt_q < 3'(DEPTH)) || pop);
    wr_pos = cnt_q - 3'(pop);
    for (int unsigned i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) buf_d[i] = buf_q[i + 1];
      buf_d[DEPTH-1] = '0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && (3'(i) == wr_pos)) buf_d[i] = random128;
    end
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
    gnt_d    = pop ? (NUM_REQ'(1) << sel) : '0;
    rand_d   = pop ? buf_q[0] : rand_q;
    served_d = served_q + 32'(pop);
    ptr_d    = ptr_q;
    if (pop) ptr_d = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_WARM;
      warm_q   <= '0;
      bad_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rand_q   <= '0;
      stuck_q  <= 1'b0;
      served_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      bad_q    <= bad_d;
      prev_q   <= random128;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rand_q   <= rand_d;
      stuck_q  <= stuck_d;
      served_q <= served_d;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign gnt        = gnt_q;
  assign rand_out   = rand_q;
  assign buf_cnt    = cnt_q;
  assign lfsr_stuck = stuck_q;
  assign served_cnt = served_q;

endmodule
